// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: 64-bit AXI-lite bus shared by the UART read master and the memory write master
// Ports: none; signals araddr/arvalid/arready/rdata/rresp/rvalid/rready (read channels) and
// awaddr/awvalid/awready/wdata/wstrb/wvalid/wready/bresp/bvalid/bready (write channels).
// Modports: rd_mst/rd_slv carry only the read channels, wr_mst/wr_slv only the write channels.
interface uart_boot_loader_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport rd_mst (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport rd_slv (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
  modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready, input awready, wready, bresp, bvalid);
  modport wr_slv (input awaddr, awvalid, wdata, wstrb, wvalid, bready, output awready, wready, bresp, bvalid);
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pulls a boot image from the UART RX buffer over AXI-lite and writes it to memory
// Ports: clk, rst_n (async active-low), i_enable (start, sampled in idle),
// uart_rd (AXI-lite read master to UART: +0 RX count, +8 pop word), mem_wr (AXI-lite write master to memory),
// o_busy, o_done (sticky), o_error (sticky), o_cpu_rst_n (low until done), o_words_loaded.
// Option: BOOT_CHECKSUM_EN adds an XOR trailer word checked after the payload.
module uart_boot_loader #(
  parameter logic [63:0] UART_BASE_ADDR = 64'h0,
  parameter int          POLL_INTERVAL  = 16,
  parameter int          MAX_WORDS      = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  uart_boot_loader_if.rd_mst uart_rd,
  uart_boot_loader_if.wr_mst mem_wr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic               o_cpu_rst_n,
  output logic [31:0]        o_words_loaded
);
  typedef enum logic [3:0] {S_IDLE, S_WAIT, S_CNT_AR, S_CNT_R, S_POP_AR, S_POP_R, S_WR, S_B, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CSUM} phase_t;
  state_t      r_state, w_state_nxt;
  phase_t      r_phase, w_phase_nxt;
  logic [15:0] r_cnt;
  logic [28:0] r_base;
  logic [31:0] r_n;
  logic [63:0] r_data;
  logic [31:0] r_words;
  logic        r_rel;
`ifdef BOOT_CHECKSUM_EN
  logic [63:0] r_xor;
`endif
  logic [31:0] w_n;
  logic        w_last;
  logic        w_pop;
  logic        w_unused;
  assign w_n      = uart_rd.rdata[31:0];
  assign w_last   = (r_words + 32'd1) == r_n;
  assign w_pop    = r_state == S_POP_R && uart_rd.rvalid;
  assign w_unused = ^{uart_rd.rresp, mem_wr.bresp};
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      S_IDLE:   if (i_enable) w_state_nxt = S_WAIT;
      S_WAIT:   if (r_cnt == 16'd0) w_state_nxt = S_CNT_AR;
      S_CNT_AR: if (uart_rd.arready) w_state_nxt = S_CNT_R;
      S_CNT_R:  if (uart_rd.rvalid) w_state_nxt = uart_rd.rdata >= 64'd8 ? S_POP_AR : S_WAIT;
      S_POP_AR: if (uart_rd.arready) w_state_nxt = S_POP_R;
      S_POP_R:
        if (uart_rd.rvalid) begin
          if (r_phase == PH_HDR) begin
            if (w_n > 32'(MAX_WORDS)) w_state_nxt = S_ERR;
            else if (w_n == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
              w_state_nxt = S_WAIT;
              w_phase_nxt = PH_CSUM;
`else
              w_state_nxt = S_DONE;
`endif
            end else begin
              w_state_nxt = S_WAIT;
              w_phase_nxt = PH_DATA;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          else if (r_phase == PH_CSUM) w_state_nxt = uart_rd.rdata == r_xor ? S_DONE : S_ERR;
`endif
          else w_state_nxt = S_WR;
        end
      S_WR:     if (mem_wr.awready && mem_wr.wready) w_state_nxt = S_B;
      S_B:
        if (mem_wr.bvalid) begin
          if (w_last) begin
`ifdef BOOT_CHECKSUM_EN
            w_state_nxt = S_WAIT;
            w_phase_nxt = PH_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end else w_state_nxt = S_WAIT;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= PH_HDR;
      r_cnt   <= '0;
      r_base  <= '0;
      r_n     <= '0;
      r_data  <= '0;
      r_words <= '0;
      r_rel   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= r_state == S_WAIT ? r_cnt - 16'd1 : 16'(POLL_INTERVAL - 1);
      r_rel   <= r_rel || r_state == S_DONE;
      if (w_pop && r_phase == PH_HDR) begin
        r_base <= uart_rd.rdata[63:35];
        r_n    <= w_n;
      end
      if (w_pop && r_phase == PH_DATA) begin
        r_data <= uart_rd.rdata;
`ifdef BOOT_CHECKSUM_EN
        r_xor  <= r_xor ^ uart_rd.rdata;
`endif
      end
      if (r_state == S_B && mem_wr.bvalid && !(&r_words)) r_words <= r_words + 32'd1;
    end
  end
  assign uart_rd.araddr  = r_state == S_POP_AR ? UART_BASE_ADDR + 64'd8 : UART_BASE_ADDR;
  assign uart_rd.arvalid = r_state == S_CNT_AR || r_state == S_POP_AR;
  assign uart_rd.rready  = r_state == S_CNT_R || r_state == S_POP_R;
  assign mem_wr.awaddr   = {32'h0, r_base + r_words[28:0], 3'b000};
  assign mem_wr.awvalid  = r_state == S_WR;
  assign mem_wr.wvalid   = r_state == S_WR;
  assign mem_wr.wdata    = r_data;
  assign mem_wr.wstrb    = 8'hFF;
  assign mem_wr.bready   = r_state == S_B;
  assign o_busy          = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign o_done          = r_state == S_DONE;
  assign o_error         = r_state == S_ERR;
  assign o_cpu_rst_n     = r_rel;
  assign o_words_loaded  = r_words;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed bench with a UART RX model and a memory write slave
module tb_uart_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        busy, done, error, cpu_rst_n;
  logic [31:0] words;
  logic        aw_rdy = 1'b1, w_rdy = 1'b1, b_en = 1'b1, pend;
  logic [63:0] q_pop[$], q_cnt[$], wa[$], wd[$];
  logic [63:0] cnt, last_cnt;
  int          gaps[$];
  int          pops, polls, first_pop_poll, bad_pop, idle, overlap, bad_strb;
  int          checks = 0, errors = 0;
  uart_boot_loader_if u_if();
  uart_boot_loader_if m_if();
  uart_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .uart_rd(u_if.rd_mst), .mem_wr(m_if.wr_mst),
    .o_busy(busy), .o_done(done), .o_error(error), .o_cpu_rst_n(cpu_rst_n), .o_words_loaded(words)
  );
  always #5 clk = ~clk;
  assign {u_if.awaddr, u_if.awvalid, u_if.awready, u_if.wdata, u_if.wstrb, u_if.wvalid, u_if.wready, u_if.bresp, u_if.bvalid, u_if.bready} = '0;
  assign {m_if.araddr, m_if.arvalid, m_if.arready, m_if.rdata, m_if.rresp, m_if.rvalid, m_if.rready} = '0;
  assign u_if.arready = 1'b1;
  assign u_if.rresp   = 2'b00;
  assign m_if.awready = aw_rdy;
  assign m_if.wready  = w_rdy;
  assign m_if.bresp   = 2'b00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_if.rvalid <= 1'b0; u_if.rdata <= '0; pops <= 0; polls <= 0; first_pop_poll <= 0;
      bad_pop <= 0; last_cnt <= '0; idle <= 0; gaps.delete();
    end else begin
      if (u_if.rvalid && u_if.rready) u_if.rvalid <= 1'b0;
      if (u_if.arvalid && u_if.arready) begin
        u_if.rvalid <= 1'b1;
        if (u_if.araddr == 64'h8) begin
          pops <= pops + 1;
          if (pops == 0) first_pop_poll <= polls;
          if (last_cnt < 64'd8 || q_pop.size() == 0) bad_pop <= bad_pop + 1;
          if (q_pop.size() > 0) u_if.rdata <= q_pop.pop_front();
          else u_if.rdata <= '0;
        end else begin
          if (q_cnt.size() > 0) cnt = q_cnt.pop_front();
          else cnt = 64'(q_pop.size() * 8);
          last_cnt <= cnt; u_if.rdata <= cnt; polls <= polls + 1; gaps.push_back(idle); idle <= 0;
        end
      end else if (busy && !u_if.arvalid && !u_if.rready && !m_if.awvalid && !m_if.bready) idle <= idle + 1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if.bvalid <= 1'b0; pend <= 1'b0; wa.delete(); wd.delete(); bad_strb <= 0; overlap <= 0;
    end else begin
      if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
      if (pend && b_en && !m_if.bvalid) begin m_if.bvalid <= 1'b1; pend <= 1'b0; end
      if (m_if.awvalid && m_if.wvalid && m_if.awready && m_if.wready) begin
        pend <= 1'b1; wa.push_back(m_if.awaddr); wd.push_back(m_if.wdata);
        if (m_if.wstrb !== 8'hFF) bad_strb <= bad_strb + 1;
      end
      if ((u_if.arvalid || u_if.rready) && (m_if.awvalid || m_if.wvalid || m_if.bready)) overlap <= overlap + 1;
    end
  end
  task automatic do_reset();
    enable = 1'b0; aw_rdy = 1'b1; w_rdy = 1'b1; b_en = 1'b1;
    q_pop.delete(); q_cnt.delete();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_end(input string nm);
    for (int i = 0; i < 5000 && !(done || error); i++) @(negedge clk);
    checks++;
    if (!(done || error)) begin errors++; $display("FAIL %s_timeout done=%b error=%b required one of them high", nm, done, error); end
  endtask
  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if ({busy, done, error, cpu_rst_n} !== 4'b0) begin errors++; $display("FAIL reset_status got %b required 0000", {busy, done, error, cpu_rst_n}); end
    checks++;
    if (words !== 32'd0) begin errors++; $display("FAIL reset_words got %0d required 0", words); end
    checks++;
    if ({u_if.arvalid, u_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b required 00000", {u_if.arvalid, u_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready});
    end
    n = 0;
    repeat (100) begin @(negedge clk); if (u_if.arvalid) n++; end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL idle_arvalid got %0d cycles required 0", n); end
    checks++;
    if ({cpu_rst_n, busy} !== 2'b00) begin errors++; $display("FAIL idle_status got %b required 00", {cpu_rst_n, busy}); end
  endtask
  task automatic test_load();
    logic [63:0] ea[3], ed[3];
    int g;
    ea = '{64'h1000, 64'h1008, 64'h1010};
    ed = '{64'hAAAA_0000_1111_0001, 64'hBBBB_2222_0000_0002, 64'hCCCC_3333_4444_0003};
    do_reset();
    q_cnt.push_back(64'd5); q_cnt.push_back(64'd8);
    q_pop.push_back({32'h0000_1003, 32'd3});
    for (int i = 0; i < 3; i++) q_pop.push_back(ed[i]);
`ifdef BOOT_CHECKSUM_EN
    q_pop.push_back(ed[0] ^ ed[1] ^ ed[2]);
`endif
    enable = 1'b1;
    wait_end("load");
    checks++;
    if (first_pop_poll !== 2) begin errors++; $display("FAIL first_pop_after_poll got %0d required 2", first_pop_poll); end
    g = gaps.size() > 1 ? gaps[1] : -1;
    checks++;
    if (g !== 16) begin errors++; $display("FAIL poll_gap got %0d required 16", g); end
    checks++;
    if (bad_pop !== 0) begin errors++; $display("FAIL early_pop got %0d required 0", bad_pop); end
    checks++;
    if (wa.size() !== 3) begin errors++; $display("FAIL load_write_count got %0d required 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++; $display("FAIL load_write%0d got %h/%h required %h/%h", i, i < wa.size() ? wa[i] : 64'hx, i < wd.size() ? wd[i] : 64'hx, ea[i], ed[i]);
      end
    end
    checks++;
    if (words !== 32'd3) begin errors++; $display("FAIL load_words got %0d required 3", words); end
    checks++;
    if ({done, error, cpu_rst_n, busy} !== 4'b1000) begin errors++; $display("FAIL load_done_edge got %b required 1000", {done, error, cpu_rst_n, busy}); end
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL cpu_release got %b required 1", cpu_rst_n); end
    checks++;
    if (overlap !== 0 || bad_strb !== 0) begin errors++; $display("FAIL bus_rules got overlap=%0d strb=%0d required 0/0", overlap, bad_strb); end
  endtask
  task automatic test_bad_header();
    do_reset();
    q_pop.push_back({32'h0000_0000, 32'd4097});
    enable = 1'b1;
    wait_end("bad_hdr");
    repeat (5) @(negedge clk);
    checks++;
    if ({error, done, cpu_rst_n, busy} !== 4'b1000) begin errors++; $display("FAIL bad_hdr_status got %b required 1000", {error, done, cpu_rst_n, busy}); end
    checks++;
    if (wa.size() !== 0) begin errors++; $display("FAIL bad_hdr_writes got %0d required 0", wa.size()); end
  endtask
  task automatic test_zero_words();
    do_reset();
    q_pop.push_back({32'h0000_3000, 32'd0});
`ifdef BOOT_CHECKSUM_EN
    q_pop.push_back(64'd0);
`endif
    enable = 1'b1;
    wait_end("zero");
    checks++;
    if ({done, error} !== 2'b10 || wa.size() !== 0 || words !== 32'd0) begin
      errors++; $display("FAIL zero_words got done=%b error=%b writes=%0d words=%0d required 1/0/0/0", done, error, wa.size(), words);
    end
  endtask
  task automatic test_stall_reset();
    logic [63:0] d;
    int held;
    d = 64'h0123_4567_89AB_CDEF;
    do_reset();
    w_rdy = 1'b0; b_en = 1'b0;
    q_pop.push_back({32'h0000_2000, 32'd1});
    q_pop.push_back(d);
`ifdef BOOT_CHECKSUM_EN
    q_pop.push_back(d);
`endif
    enable = 1'b1;
    for (int i = 0; i < 3000 && !m_if.awvalid; i++) @(negedge clk);
    checks++;
    if (m_if.awvalid !== 1'b1) begin errors++; $display("FAIL stall_awvalid_timeout got %b required 1", m_if.awvalid); end
    held = 0;
    repeat (10) begin
      if (m_if.awvalid && m_if.wvalid && m_if.awaddr == 64'h2000 && m_if.wdata == d) held++;
      @(negedge clk);
    end
    checks++;
    if (held !== 10) begin errors++; $display("FAIL stall_hold got %0d cycles required 10", held); end
    checks++;
    if (wa.size() !== 0) begin errors++; $display("FAIL stall_early_write got %0d required 0", wa.size()); end
    w_rdy = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 64'h2000 || wd[0] !== d) begin errors++; $display("FAIL stall_one_write got %0d writes required 1 at 2000", wa.size()); end
    checks++;
    if ({m_if.bready, busy, m_if.awvalid} !== 3'b110) begin errors++; $display("FAIL in_b_state got %b required 110", {m_if.bready, busy, m_if.awvalid}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, cpu_rst_n, m_if.bready, m_if.awvalid, u_if.arvalid, u_if.rready} !== 8'b0 || words !== 32'd0) begin
      errors++; $display("FAIL async_reset got %b words=%0d required 00000000 words=0", {busy, done, error, cpu_rst_n, m_if.bready, m_if.awvalid, u_if.arvalid, u_if.rready}, words);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);
  endtask
`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    q_pop.push_back({32'h0000_4000, 32'd2});
    q_pop.push_back(64'd1); q_pop.push_back(64'd2); q_pop.push_back(64'd3);
    enable = 1'b1;
    wait_end("csum_ok");
    checks++;
    if ({done, error} !== 2'b10 || words !== 32'd2) begin errors++; $display("FAIL csum_ok got done=%b error=%b words=%0d required 1/0/2", done, error, words); end
    do_reset();
    q_pop.push_back({32'h0000_4000, 32'd2});
    q_pop.push_back(64'd1); q_pop.push_back(64'd2); q_pop.push_back(64'd4);
    enable = 1'b1;
    wait_end("csum_bad");
    repeat (3) @(negedge clk);
    checks++;
    if ({done, error, cpu_rst_n} !== 3'b010 || wa.size() !== 2) begin
      errors++; $display("FAIL csum_bad got done=%b error=%b cpu_rst_n=%b writes=%0d required 0/1/0/2", done, error, cpu_rst_n, wa.size());
    end
  endtask
`endif
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_load();
    test_bad_header();
    test_zero_words();
    test_stall_reset();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
